// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, special
// instruction words and MIPS-style field positions.
package if_stage_pkg;

    // Fetch FSM encoding
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StHalt = 2'd2;

    // Bubble injected on flush/idle; all-zero decodes as sll $0,$0,0
    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

    // Instruction field positions
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_MSB     = 25;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_MSB     = 20;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_MSB     = 15;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;

    // J-type target: region bits of the jump's own PC+4 plus the 26-bit word index
    function automatic logic [31:0] jump_target(input logic [3:0]  pc_region,
                                                input logic [25:0] instr_index);
        return {pc_region, instr_index, 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_instr_mem.sv
// Word-addressed instruction memory: one synchronous write port for program
// load, one asynchronous read port for fetch. Contents are never reset.
module if_stage_instr_mem #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem [MEM_DEPTH];

    // Program-load write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with PC, next-PC selection, IF/ID pipeline register
// and an IDLE/RUN/HALT control FSM. Program memory is loadable only while idle.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned ADDR_W     = $clog2(MEM_DEPTH),
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_prog_we,
    input  logic [ADDR_W-1:0] i_prog_addr,
    input  logic [31:0]       i_prog_data,
    input  logic              i_stall,
    input  logic              i_pc_src,
    input  logic [31:0]       i_beq_jump_dir,
    input  logic              i_jump,
    output logic [31:0]       o_instruction,
    output logic [31:0]       o_pc_plus_4,
    output logic [5:0]        o_opcode,
    output logic [4:0]        o_rs,
    output logic [4:0]        o_rt,
    output logic [4:0]        o_rd,
    output logic [5:0]        o_function_code,
    output logic [15:0]       o_beq_offset,
    output logic [31:0]       o_pc,
    output logic              o_halt
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] fetched;
    logic [31:0] pc_plus_4;
    logic        mem_we;

    // Loads are accepted only in IDLE and never while reset is asserted
    assign mem_we    = i_reset && (state_q == StIdle) && i_prog_we;
    assign pc_plus_4 = pc_q + 32'd4;

    if_stage_instr_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_instr_mem (
        .clk_i   (i_clk),
        .we_i    (mem_we),
        .waddr_i (i_prog_addr),
        .wdata_i (i_prog_data),
        .raddr_i (pc_q[ADDR_W+1:2]),
        .rdata_o (fetched)
    );

    // Next-state, next-PC and IF/ID selection
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        case (state_q)
            StIdle: begin
                pc_d         = '0;
                ifid_instr_d = NOP_INSTR;
                ifid_pc4_d   = '0;
                if (i_enable && !i_prog_we) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!i_enable) begin
                    state_d      = StIdle;
                    pc_d         = '0;
                    ifid_instr_d = NOP_INSTR;
                    ifid_pc4_d   = '0;
                end else if (i_stall) begin
                    // hold everything; redirects wait until the stall clears
                end else if (i_pc_src) begin
                    pc_d         = i_beq_jump_dir & ~32'h3;
                    ifid_instr_d = NOP_INSTR;
                    ifid_pc4_d   = '0;
                end else if (i_jump) begin
                    pc_d         = jump_target(ifid_pc4_q[31:28], ifid_instr_q[25:0]);
                    ifid_instr_d = NOP_INSTR;
                    ifid_pc4_d   = '0;
                end else if (fetched == HALT_INSTR) begin
                    // pass HALT downstream so later stages can drain; PC parks here
                    ifid_instr_d = HALT_INSTR;
                    ifid_pc4_d   = pc_plus_4;
                    state_d      = StHalt;
                end else begin
                    pc_d         = pc_plus_4;
                    ifid_instr_d = fetched;
                    ifid_pc4_d   = pc_plus_4;
                end
            end
            StHalt: begin
                if (!i_enable) begin
                    state_d      = StIdle;
                    pc_d         = '0;
                    ifid_instr_d = NOP_INSTR;
                    ifid_pc4_d   = '0;
                end else if (!i_stall) begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_pc4_d   = '0;
                end
            end
            default: begin
                state_d      = StIdle;
                pc_d         = '0;
                ifid_instr_d = NOP_INSTR;
                ifid_pc4_d   = '0;
            end
        endcase
    end

    // PC, IF/ID and FSM state registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

    assign o_instruction   = ifid_instr_q;
    assign o_pc_plus_4     = ifid_pc4_q;
    assign o_opcode        = ifid_instr_q[OPCODE_MSB:OPCODE_LSB];
    assign o_rs            = ifid_instr_q[RS_MSB:RS_LSB];
    assign o_rt            = ifid_instr_q[RT_MSB:RT_LSB];
    assign o_rd            = ifid_instr_q[RD_MSB:RD_LSB];
    assign o_function_code = ifid_instr_q[FUNCT_MSB:FUNCT_LSB];
    assign o_beq_offset    = ifid_instr_q[IMM_MSB:IMM_LSB];
    assign o_pc            = pc_q;
    assign o_halt          = (state_q == StHalt);

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
module tb_if_stage;

    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned ADDR_W    = 8;

    localparam logic [31:0] INS_A  = 32'h8C01_0004;
    localparam logic [31:0] INS_B  = 32'h0022_1820;
    localparam logic [31:0] INS_C  = 32'h1043_0002;
    localparam logic [31:0] INS_D  = 32'h0064_2822;
    localparam logic [31:0] INS_J  = 32'h0800_0010;
    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              i_reset;
    logic              i_enable;
    logic              i_prog_we;
    logic [ADDR_W-1:0] i_prog_addr;
    logic [31:0]       i_prog_data;
    logic              i_stall;
    logic              i_pc_src;
    logic [31:0]       i_beq_jump_dir;
    logic              i_jump;
    logic [31:0]       o_instruction;
    logic [31:0]       o_pc_plus_4;
    logic [5:0]        o_opcode;
    logic [4:0]        o_rs;
    logic [4:0]        o_rt;
    logic [4:0]        o_rd;
    logic [5:0]        o_function_code;
    logic [15:0]       o_beq_offset;
    logic [31:0]       o_pc;
    logic              o_halt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_stage #(
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_enable        (i_enable),
        .i_prog_we       (i_prog_we),
        .i_prog_addr     (i_prog_addr),
        .i_prog_data     (i_prog_data),
        .i_stall         (i_stall),
        .i_pc_src        (i_pc_src),
        .i_beq_jump_dir  (i_beq_jump_dir),
        .i_jump          (i_jump),
        .o_instruction   (o_instruction),
        .o_pc_plus_4     (o_pc_plus_4),
        .o_opcode        (o_opcode),
        .o_rs            (o_rs),
        .o_rt            (o_rt),
        .o_rd            (o_rd),
        .o_function_code (o_function_code),
        .o_beq_offset    (o_beq_offset),
        .o_pc            (o_pc),
        .o_halt          (o_halt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic [31:0] pc);
        chk({tag, ".instr"}, o_instruction, instr);
        chk({tag, ".pc4"}, o_pc_plus_4, pc4);
        chk({tag, ".pc"}, o_pc, pc);
    endtask

    task automatic load(input int unsigned addr, input logic [31:0] data);
        i_prog_we   = 1'b1;
        i_prog_addr = addr[ADDR_W-1:0];
        i_prog_data = data;
        step();
        i_prog_we   = 1'b0;
    endtask

    initial begin
        i_reset        = 1'b0;
        i_enable       = 1'b0;
        i_prog_we      = 1'b0;
        i_prog_addr    = '0;
        i_prog_data    = '0;
        i_stall        = 1'b0;
        i_pc_src       = 1'b0;
        i_beq_jump_dir = '0;
        i_jump         = 1'b0;
        step();
        step();
        chk_ifid("reset", 32'h0, 32'h0, 32'h0);
        chk("reset.halt", {31'b0, o_halt}, 32'h0);

        // Program load in IDLE
        i_reset = 1'b1;
        load(0, INS_A);
        load(1, INS_B);
        load(2, INS_C);
        load(3, INS_D);
        for (int i = 4; i < 10; i++) load(i, 32'hA000_0000 | i);
        load(16, 32'hA000_0010);
        chk_ifid("idle_after_load", 32'h0, 32'h0, 32'h0);

        // 1) Sequential fetch
        i_enable = 1'b1;
        step();
        chk_ifid("run_entry", 32'h0, 32'h0, 32'h0);
        step(); chk_ifid("t1_a", INS_A, 32'd4, 32'd4);
        step(); chk_ifid("t1_b", INS_B, 32'd8, 32'd8);
        step(); chk_ifid("t1_c", INS_C, 32'd12, 32'd12);
        step(); chk_ifid("t1_d", INS_D, 32'd16, 32'd16);

        // Disable returns to IDLE with PC cleared
        i_enable = 1'b0;
        step(); chk_ifid("disable", 32'h0, 32'h0, 32'h0);

        // 2) Stall holds B; redirects asserted during the stall must be ignored
        i_enable = 1'b1;
        step(); step(); step();
        chk_ifid("t2_b", INS_B, 32'd8, 32'd8);
        chk("t2_opcode", {26'b0, o_opcode}, 32'h0);
        chk("t2_rs", {27'b0, o_rs}, 32'd1);
        chk("t2_rt", {27'b0, o_rt}, 32'd2);
        chk("t2_rd", {27'b0, o_rd}, 32'd3);
        chk("t2_funct", {26'b0, o_function_code}, 32'h20);
        chk("t2_offset", {16'b0, o_beq_offset}, 32'h1820);
        i_stall = 1'b1; i_pc_src = 1'b1; i_jump = 1'b1; i_beq_jump_dir = 32'h40;
        step(); chk_ifid("t2_stall1", INS_B, 32'd8, 32'd8);
        step(); chk_ifid("t2_stall2", INS_B, 32'd8, 32'd8);

        // 3) Branch taken at PC=8
        i_stall = 1'b0; i_jump = 1'b0; i_beq_jump_dir = 32'h20;
        step();
        chk("t3_flush.instr", o_instruction, 32'h0);
        chk("t3_flush.pc", o_pc, 32'h20);
        i_pc_src = 1'b0;
        step(); chk_ifid("t3_target", 32'hA000_0008, 32'h24, 32'h24);

        // Branch beats jump; target low bits masked
        i_pc_src = 1'b1; i_jump = 1'b1; i_beq_jump_dir = 32'h13;
        step();
        chk("t3_both.instr", o_instruction, 32'h0);
        chk("t3_both.pc", o_pc, 32'h10);
        i_jump = 1'b0; i_beq_jump_dir = 32'h403;
        step();
        chk("t3_wrap_br.pc", o_pc, 32'h400);
        i_pc_src = 1'b0;
        step(); chk_ifid("t3_wrap_fetch", INS_A, 32'h404, 32'h404);

        // 4) J-type jump from IF/ID
        i_enable = 1'b0;
        step();
        load(0, INS_J);
        i_enable = 1'b1;
        step(); step();
        chk_ifid("t4_j", INS_J, 32'd4, 32'd4);
        chk("t4_opcode", {26'b0, o_opcode}, 32'h2);
        i_jump = 1'b1;
        step();
        chk("t4_flush.instr", o_instruction, 32'h0);
        chk("t4_flush.pc", o_pc, 32'h40);
        i_jump = 1'b0;
        step(); chk_ifid("t4_target", 32'hA000_0010, 32'h44, 32'h44);

        // 5) HALT at mem[2]
        i_enable = 1'b0;
        step();
        load(0, INS_A);
        load(2, HALT_W);
        i_enable = 1'b1;
        step(); step(); step();
        chk_ifid("t5_b", INS_B, 32'd8, 32'd8);
        chk("t5_pre.halt", {31'b0, o_halt}, 32'h0);
        step();
        chk_ifid("t5_halt_instr", HALT_W, 32'd12, 32'd8);
        chk("t5_halt", {31'b0, o_halt}, 32'h1);
        load(3, 32'h1234_5678);
        chk("t5_nop.instr", o_instruction, 32'h0);
        chk("t5_nop.pc", o_pc, 32'd8);
        chk("t5_nop.halt", {31'b0, o_halt}, 32'h1);
        i_enable = 1'b0;
        step();
        chk("t5_exit.pc", o_pc, 32'h0);
        chk("t5_exit.halt", {31'b0, o_halt}, 32'h0);

        // Redirect cancels a HALT fetched the same cycle; mem[3] kept its D
        i_enable = 1'b1;
        step(); step(); step();
        i_pc_src = 1'b1; i_beq_jump_dir = 32'h0C;
        step();
        chk("t5_cancel.instr", o_instruction, 32'h0);
        chk("t5_cancel.pc", o_pc, 32'h0C);
        chk("t5_cancel.halt", {31'b0, o_halt}, 32'h0);
        i_pc_src = 1'b0;
        step(); chk_ifid("t5_d_kept", INS_D, 32'h10, 32'h10);

        // 6) Reset mid-RUN at PC=0x0C
        i_pc_src = 1'b1; i_beq_jump_dir = 32'h0C;
        step();
        i_pc_src = 1'b0;
        chk("t6_pre.pc", o_pc, 32'h0C);
        i_reset = 1'b0;
        step();
        chk_ifid("t6_reset", 32'h0, 32'h0, 32'h0);
        chk("t6_reset.halt", {31'b0, o_halt}, 32'h0);
        i_reset = 1'b1;
        step();
        chk_ifid("t6_idle_to_run", 32'h0, 32'h0, 32'h0);
        step();
        chk_ifid("t6_mem_kept", INS_A, 32'd4, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
